// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and constants for the memory responder
//
// Purpose: FSM state encoding, bus direction encoding shared with the control
//          unit, default widths and the wait-counter load helper.
// Ports:   none (package).

package mem_responder_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  // Bus direction as driven on mem_wre by the control unit.
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  // The WAIT state is left on the edge where the counter reads zero, so a
  // count of N wait states loads N-1.
  function automatic logic [3:0] wait_load(input int cycles);
    if (cycles > 0) begin
      return 4'(cycles - 1);
    end
    return 4'd0;
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// rtl/mem_responder_array.sv - single-port RAM with synchronous write and registered read
//
// Purpose: 2**ADDR_W x DATA_W storage. Contents are not reset; only the read
//          register is, so the read port starts at zero and holds its value
//          between reads.
// Ports:   clk, rst_n      clock, async active-low reset (read register only)
//          we_i, re_i      write / read enables (mutually exclusive by use)
//          addr_i          shared address
//          wdata_i         write data
//          rdata_o         registered read data

module mem_responder_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory-side responder with wait states, 4-phase ready and array clear
//
// Purpose: accepts a request on mem_ce, latches address/data/direction, waits
//          WAIT_CYCLES, performs one RAM access and holds mem_rdy until mem_ce
//          drops. mem_rst sweeps zeros through the whole array.
// Ports:   clk, rst_n      clock, async active-low reset
//          mem_ce          request strobe (level)
//          mem_wre         1 = write, 0 = read
//          mem_rst         array clear request (level)
//          abus, dbus_in   address and write data
//          mem_data_out    last read value
//          mem_oe          read data valid for current read
//          mem_rdy         access complete
//          mem_busy        access wait or clear in progress

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_ce,
  input  logic              mem_wre,
  input  logic              mem_rst,
  input  logic [ADDR_W-1:0] abus,
  input  logic [DATA_W-1:0] dbus_in,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_oe,
  output logic              mem_rdy,
  output logic              mem_busy
);

  localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wre_q,   wre_d;
  logic [3:0]        wait_q,  wait_d;
  logic [ADDR_W-1:0] clr_q,   clr_d;

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wre_q   <= MEM_READ;
      wait_q  <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wre_q   <= wre_d;
      wait_q  <= wait_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wre_d     = wre_q;
    wait_d    = wait_q;
    clr_d     = clr_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_rst) begin
          state_d = ST_CLEAR;
        end else if (mem_ce) begin
          addr_d  = abus;
          wdata_d = dbus_in;
          wre_d   = mem_wre;
          if (WAIT_CYCLES > 0) begin
            wait_d  = WAIT_LOAD;
            state_d = ST_WAIT;
          end else begin
            // Zero wait states: the latches are not yet loaded, so the
            // access uses the live bus values on the accept edge.
            ram_addr  = abus;
            ram_wdata = dbus_in;
            ram_we    = (mem_wre == MEM_WRITE);
            ram_re    = (mem_wre == MEM_READ);
            state_d   = ST_DONE;
          end
        end
      end

      ST_WAIT: begin
        // mem_rst is deliberately not looked at here: the access finishes first.
        if (wait_q == 4'd0) begin
          ram_we  = (wre_q == MEM_WRITE);
          ram_re  = (wre_q == MEM_READ);
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      ST_DONE: begin
        if (mem_rst) begin
          state_d = ST_CLEAR;
        end else if (!mem_ce) begin
          state_d = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_q;
        ram_wdata = '0;
        clr_d     = clr_q + 1'b1;
        // The counter wraps back to zero on the last address, ready for the
        // next sweep; a still-asserted mem_rst starts another one.
        if (clr_q == {ADDR_W{1'b1}}) begin
          state_d = mem_rst ? ST_CLEAR : ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  mem_responder_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (mem_data_out)
  );

  assign mem_rdy  = (state_q == ST_DONE);
  assign mem_oe   = (state_q == ST_DONE) && (wre_q == MEM_READ);
  assign mem_busy = (state_q == ST_WAIT) || (state_q == ST_CLEAR);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder

module tb_mem_responder;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int WC = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_ce = 1'b0;
  logic          mem_wre = 1'b0;
  logic          mem_rst = 1'b0;
  logic [AW-1:0] abus = '0;
  logic [DW-1:0] dbus_in = '0;
  logic [DW-1:0] mem_data_out;
  logic          mem_oe;
  logic          mem_rdy;
  logic          mem_busy;

  mem_responder #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_ce       (mem_ce),
    .mem_wre      (mem_wre),
    .mem_rst      (mem_rst),
    .abus         (abus),
    .dbus_in      (dbus_in),
    .mem_data_out (mem_data_out),
    .mem_oe       (mem_oe),
    .mem_rdy      (mem_rdy),
    .mem_busy     (mem_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference contents of the array, updated from the spec's rules only.
  logic [DW-1:0] model_mem [256];

  typedef struct {
    logic          wre;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full 4-phase access. With corrupt set, abus/dbus_in change after the
  // accept edge, which the DUT must ignore.
  task automatic access(input logic wre, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit corrupt, output logic [DW-1:0] rd);
    int cyc;
    bit got;
    cyc = 0;
    got = 0;
    @(negedge clk);
    mem_ce  = 1'b1;
    mem_wre = wre;
    abus    = a;
    dbus_in = d;
    while (!got && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (mem_rdy) begin
        got = 1;
      end else if (cyc == 1) begin
        check("busy_in_wait", mem_busy, 1);
        if (corrupt) begin
          abus    = 8'h20;
          dbus_in = 8'hFF;
        end
      end
    end
    check("rdy_latency", cyc, WC + 1);
    check("oe_with_rdy", mem_oe, !wre);
    check("busy_in_done", mem_busy, 0);
    if (wre) begin
      model_mem[a] = d;
    end else begin
      check("read_vs_model", mem_data_out, model_mem[a]);
    end
    rd = mem_data_out;
    mem_ce = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rdy_drop", mem_rdy, 0);
    check("oe_drop", mem_oe, 0);
    check("data_hold", mem_data_out, rd);
  endtask

  initial begin
    logic [DW-1:0] rd;
    int busy_cnt;
    bit saw_rdy;

    vt[0] = '{1'b1, 8'h10, 8'hA5, 8'h00};
    vt[1] = '{1'b0, 8'h10, 8'h00, 8'hA5};
    vt[2] = '{1'b1, 8'h20, 8'h5A, 8'h00};
    vt[3] = '{1'b1, 8'hFF, 8'hC3, 8'h00};
    vt[4] = '{1'b0, 8'h20, 8'h00, 8'h5A};
    vt[5] = '{1'b0, 8'hFF, 8'h00, 8'hC3};
    vt[6] = '{1'b1, 8'h10, 8'h66, 8'h00};
    vt[7] = '{1'b0, 8'h10, 8'h00, 8'h66};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rdy", mem_rdy, 0);
    check("rst_oe", mem_oe, 0);
    check("rst_busy", mem_busy, 0);
    check("rst_data", mem_data_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", mem_rdy, 0);
    check("post_rst_busy", mem_busy, 0);

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      access(vt[i].wre, vt[i].addr, vt[i].data, 1'b0, rd);
      if (!vt[i].wre) begin
        check("vec_read", rd, vt[i].exp);
      end
    end

    // Bus changes during WAIT are ignored
    access(1'b1, 8'h11, 8'h3C, 1'b1, rd);
    access(1'b0, 8'h11, 8'h00, 1'b0, rd);
    check("latched_write", rd, 8'h3C);
    access(1'b0, 8'h20, 8'h00, 1'b0, rd);
    check("untouched_addr", rd, 8'h5A);

    // Clear with mem_ce asserted; ce must be ignored throughout
    @(negedge clk);
    mem_rst = 1'b1;
    mem_ce  = 1'b1;
    mem_wre = 1'b1;
    abus    = 8'h10;
    dbus_in = 8'h99;
    busy_cnt = 0;
    saw_rdy  = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      @(negedge clk);
      mem_rst = 1'b0;
      if (n == 200) mem_ce = 1'b0;
      if (mem_rdy) saw_rdy = 1;
      if (mem_busy) busy_cnt++;
      else break;
    end
    check("clear_cycles", busy_cnt, 256);
    check("clear_no_rdy", saw_rdy, 0);
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    access(1'b0, 8'h10, 8'h00, 1'b0, rd);
    check("cleared_10", rd, 8'h00);
    access(1'b0, 8'hFF, 8'h00, 1'b0, rd);
    check("cleared_ff", rd, 8'h00);

    // Randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      logic          w;
      logic [AW-1:0] a;
      w = 1'($urandom % 2);
      a = ($urandom % 2) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      access(w, a, 8'($urandom), 1'b0, rd);
    end

    // Async reset in the middle of a write's WAIT
    access(1'b1, 8'h05, 8'h12, 1'b0, rd);
    access(1'b0, 8'h05, 8'h00, 1'b0, rd);
    @(negedge clk);
    mem_ce  = 1'b1;
    mem_wre = 1'b1;
    abus    = 8'h05;
    dbus_in = 8'h77;
    @(posedge clk);
    @(negedge clk);
    check("mid_wait_busy", mem_busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", mem_busy, 0);
    check("async_rst_rdy", mem_rdy, 0);
    check("async_rst_oe", mem_oe, 0);
    check("async_rst_data", mem_data_out, 0);
    mem_ce = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 8'h05, 8'h00, 1'b0, rd);
    check("dropped_write", rd, 8'h12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
